// File: rtl/mem_stage.sv
// Memory-stage controller between EX/MEM and MEM/WB: issues fixed-latency SRAM
// loads/stores and freezes the upstream pipeline until each access completes.
module mem_stage #(
  parameter int unsigned WAIT_CYCLES = 5,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       st_val,
  input  logic [3:0]        dest,
  input  logic [31:0]       sram_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic              sram_we,
  output logic              sram_re,
  output logic              freeze,
  output logic              wb_en_out,
  output logic              mem_read_out,
  output logic [31:0]       alu_result_out,
  output logic [31:0]       mem_data,
  output logic [3:0]        dest_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       op_write;
  logic       req;

  assign req = mem_read | mem_write;

  // Freeze rises combinationally in IDLE so the request cycle itself stalls.
  always_comb begin
    state_nxt = state;
    freeze    = 1'b0;
    sram_we   = 1'b0;
    sram_re   = 1'b0;
    unique case (state)
      IDLE: begin
        freeze = req;
        if (req) state_nxt = ACCESS;
      end
      ACCESS: begin
        freeze  = 1'b1;
        sram_we = op_write;
        sram_re = ~op_write;
        if (cnt == 4'd0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      op_write   <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= 32'd0;
      mem_data   <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req) begin
            // Modular subtract: addresses below the base wrap, then truncate.
            sram_addr  <= ADDR_W'((alu_result - BASE_ADDR) >> 2);
            sram_wdata <= st_val;
            op_write   <= mem_write;
            cnt        <= CNT_INIT;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!op_write) mem_data <= sram_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Bubbles go to MEM/WB while stalled; everything else is pass-through.
  assign wb_en_out      = wb_en & ~freeze;
  assign mem_read_out   = mem_read & ~freeze;
  assign alu_result_out = alu_result;
  assign dest_out       = dest;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: scoreboard of expected SRAM transactions and
// MEM/WB results, checked with immediate assertions as each access completes.
module tb_mem_stage;

  localparam int WAIT = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] alu_result;
  logic [31:0] st_val;
  logic [3:0]  dest;
  logic [31:0] sram_rdata;
  logic [15:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_we;
  logic        sram_re;
  logic        freeze;
  logic        wb_en_out;
  logic        mem_read_out;
  logic [31:0] alu_result_out;
  logic [31:0] mem_data;
  logic [3:0]  dest_out;

  mem_stage #(.WAIT_CYCLES(WAIT), .BASE_ADDR(32'd1024), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .wb_en(wb_en), .mem_read(mem_read),
    .mem_write(mem_write), .alu_result(alu_result), .st_val(st_val),
    .dest(dest), .sram_rdata(sram_rdata), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_we(sram_we), .sram_re(sram_re),
    .freeze(freeze), .wb_en_out(wb_en_out), .mem_read_out(mem_read_out),
    .alu_result_out(alu_result_out), .mem_data(mem_data), .dest_out(dest_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic        wb;
    logic [3:0]  dst;
    logic [31:0] alu;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] mdata;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_mem;
  int          n_assert;
  int          n_fail;
  int          cyc;
  int          done_cyc;
  int          done_cyc_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive one EX/MEM memory instruction and queue what it must produce.
  task automatic issue(input logic w, input logic r, input logic wb, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] ds, input logic [31:0] rword);
    exp_t        e;
    logic [31:0] off;
    mem_write  = w;
    mem_read   = r;
    wb_en      = wb;
    alu_result = a;
    st_val     = d;
    dest       = ds;
    off        = a - 32'd1024;
    if (!w) model_mem = rword;
    e.wr    = w;
    e.rd    = r;
    e.wb    = wb;
    e.dst   = ds;
    e.alu   = a;
    e.addr  = off[17:2];
    e.wdata = d;
    e.rdata = rword;
    e.mdata = model_mem;
    sb_q.push_back(e);
  endtask

  // Called right after the edge that presents the request; runs to DONE.
  task automatic finish_op();
    exp_t e;
    int   fz;
    int   sbc;
    logic done_seen;
    e = sb_q[0];
    @(negedge clk);
    check("req_freeze", 32'(freeze), 32'd1);
    check("req_strobes", 32'({sram_we, sram_re}), 32'd0);
    check("req_wb_bubble", 32'(wb_en_out), 32'd0);
    fz        = 1;
    sbc       = 0;
    done_seen = 1'b0;
    for (int k = 1; k <= 20 && !done_seen; k++) begin
      tick();
      sram_rdata = (k == WAIT) ? e.rdata : $urandom();
      @(negedge clk);
      if (freeze) begin
        fz++;
        check("acc_wb_bubble", 32'(wb_en_out), 32'd0);
        check("acc_rd_bubble", 32'(mem_read_out), 32'd0);
        if (sram_we || sram_re) begin
          sbc++;
          check("acc_addr", 32'(sram_addr), 32'(e.addr));
          check("acc_we", 32'(sram_we), 32'(e.wr));
          check("acc_re", 32'(sram_re), 32'(!e.wr));
          if (e.wr) check("acc_wdata", sram_wdata, e.wdata);
        end
      end else begin
        done_seen = 1'b1;
      end
    end
    check("done_reached", 32'(done_seen), 32'd1);
    check("freeze_len", 32'(fz), 32'(WAIT + 1));
    check("strobe_len", 32'(sbc), 32'(WAIT));
    check("done_strobes", 32'({sram_we, sram_re}), 32'd0);
    check("done_wb_en", 32'(wb_en_out), 32'(e.wb));
    check("done_mem_read", 32'(mem_read_out), 32'(e.rd));
    check("done_dest", 32'(dest_out), 32'(e.dst));
    check("done_alu", alu_result_out, e.alu);
    check("done_mem_data", mem_data, e.mdata);
    void'(sb_q.pop_front());
    done_cyc_prev = done_cyc;
    done_cyc      = cyc;
    tick();
    sram_rdata = $urandom();
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    cyc        = 0;
    done_cyc   = 0;
    model_mem  = 32'd0;
    rst        = 1'b1;
    wb_en      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_result = 32'd0;
    st_val     = 32'd0;
    dest       = 4'd0;
    sram_rdata = 32'd0;

    // Reset for two cycles with no request.
    tick();
    tick();
    @(negedge clk);
    check("rst_freeze", 32'(freeze), 32'd0);
    check("rst_strobes", 32'({sram_we, sram_re}), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_wdata", sram_wdata, 32'd0);
    check("rst_mem_data", mem_data, 32'd0);
    check("rst_wb_en_out", 32'(wb_en_out), 32'd0);
    check("rst_mem_read_out", 32'(mem_read_out), 32'd0);
    rst = 1'b0;
    tick();

    // Load from word 2.
    issue(1'b0, 1'b1, 1'b1, 32'd1032, 32'd0, 4'd3, 32'hDEADBEEF);
    finish_op();

    // Store to word 0; loaded data must survive.
    issue(1'b1, 1'b0, 1'b0, 32'd1024, 32'h12345678, 4'd5, 32'd0);
    finish_op();

    // Pass-through ALU instruction.
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    wb_en      = 1'b1;
    alu_result = 32'd7;
    dest       = 4'd9;
    @(negedge clk);
    check("pt_freeze", 32'(freeze), 32'd0);
    check("pt_alu", alu_result_out, 32'd7);
    check("pt_wb_en", 32'(wb_en_out), 32'd1);
    check("pt_dest", 32'(dest_out), 32'd9);
    check("pt_strobes", 32'({sram_we, sram_re}), 32'd0);
    check("pt_mem_data", mem_data, 32'hDEADBEEF);
    tick();

    // Back-to-back load then store, second below the base (address wraps).
    issue(1'b0, 1'b1, 1'b1, 32'd1100, 32'd0, 4'd7, 32'hCAFEF00D);
    finish_op();
    issue(1'b1, 1'b0, 1'b0, 32'd1020, 32'h0BADC0DE, 4'd1, 32'd0);
    finish_op();
    check("b2b_spacing", 32'(done_cyc - done_cyc_prev), 32'(WAIT + 2));

    // Read and write together behave as a write.
    issue(1'b1, 1'b1, 1'b1, 32'd2048, 32'h55AA55AA, 4'd4, 32'h11111111);
    finish_op();

    // Reset in the third ACCESS cycle of a store, request held.
    issue(1'b1, 1'b0, 1'b0, 32'd1040, 32'hA5A5A5A5, 4'd2, 32'd0);
    @(negedge clk);
    check("ra_req_freeze", 32'(freeze), 32'd1);
    tick();
    tick();
    tick();
    @(negedge clk);
    check("ra_cycle3_we", 32'(sram_we), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("ra_we_dropped", 32'(sram_we), 32'd0);
    check("ra_re_low", 32'(sram_re), 32'd0);
    check("ra_freeze_req", 32'(freeze), 32'd1);
    check("ra_mem_cleared", mem_data, 32'd0);
    check("ra_addr_cleared", 32'(sram_addr), 32'd0);
    model_mem        = 32'd0;
    sb_q[0].mdata    = 32'd0;
    finish_op();

    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    check("end_idle_freeze", 32'(freeze), 32'd0);
    check("end_queue_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-stage controller placed at the output of the EX/MEM pipeline register. It consumes that register's `wb_en`/`mem_read`/`mem_write`/`alu_result`/`st_val`/`dest` fields and performs loads and stores against a fixed-latency external SRAM. It stalls the pipeline through an FSM until each access completes. It then presents the loaded data and the forwarded control/destination to the MEM/WB register.

## Interface
- `WAIT_CYCLES`, 5: SRAM access latency in cycles; legal range 1..15.
- `BASE_ADDR`, 32'd1024: byte address mapped to SRAM word 0.
- `ADDR_W`, 16: SRAM word-address width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wb_en`  in  1  write-back enable from EX/MEM.
- `mem_read`  in  1  load request from EX/MEM.
- `mem_write`  in  1  store request from EX/MEM.
- `alu_result`  in  32  byte address, or pass-through result.
- `st_val`  in  32  store data.
- `dest`  in  4  destination register.
- `sram_rdata`  in  32  SRAM read data; valid on the last ACCESS cycle.
- `sram_addr`  out  ADDR_W  registered word address.
- `sram_wdata`  out  32  registered store data.
- `sram_we`  out  1  write strobe, active high.
- `sram_re`  out  1  read strobe, active high.
- `freeze`  out  1  stall request to PC, IF/ID, ID/EX and EX/MEM.
- `wb_en_out`  out  1  to MEM/WB.
- `mem_read_out`  out  1  to MEM/WB.
- `alu_result_out`  out  32  to MEM/WB.
- `mem_data`  out  32  loaded word, to MEM/WB.
- `dest_out`  out  4  to MEM/WB.

## Operation
- FSM states: IDLE, ACCESS, DONE. Countdown counter `cnt` is 4 bits wide.
- Request is `req = mem_read | mem_write`.
- IDLE:
  - If `req` is low: `freeze` is 0 and the FSM stays in IDLE.
  - If `req` is high: `freeze` is 1, combinationally, in the same cycle.
  - On the next edge with `req` high: latch `sram_addr <= (alu_result - BASE_ADDR) >> 2` (low ADDR_W bits), latch `sram_wdata <= st_val`, and latch the operation type. Set `cnt <= WAIT_CYCLES-1` and go to ACCESS.
- ACCESS:
  - `freeze` is 1.
  - `sram_we` is high for a write; `sram_re` is high for a read.
  - Address and data are held stable.
  - When `cnt==0`: for a read, capture `mem_data <= sram_rdata`; go to DONE. Otherwise decrement `cnt`.
- DONE:
  - `freeze` is 0 and both strobes are 0, so the pipeline advances one instruction.
  - The next state is unconditionally IDLE. This ensures the same EX/MEM contents never retrigger an access.
- Both `mem_read` and `mem_write` high: treated as a write. `mem_data` is not updated.
- Forwarding:
  - `dest_out = dest` and `alu_result_out = alu_result`.
  - `mem_read_out = mem_read & ~freeze`.
  - `wb_en_out = wb_en & ~freeze`. Bubbles are inserted into MEM/WB while stalled.
- Non-memory instructions (`req` low) pass through with zero added latency.
- `mem_data` holds its last loaded value until the next read completes.

## Timing
- Reset values, at the first edge with `rst` high:
  - state IDLE, `cnt` 0.
  - `sram_addr`, `sram_wdata` and `mem_data` are 0.
  - `sram_we` and `sram_re` are 0.
  - `freeze` is 0 unless `req` is high. The combinational `freeze` rule applies in IDLE.
- Access latency: `freeze` is high for WAIT_CYCLES+1 cycles: the request cycle plus WAIT_CYCLES ACCESS cycles. DONE is cycle WAIT_CYCLES+1 after the request is first seen.
- For WAIT_CYCLES=5: request in cycle 0, ACCESS in cycles 1–5, DONE in cycle 6.
- Strobes are high for exactly WAIT_CYCLES cycles per access.
- Back-to-back memory ops: a new request is seen in the IDLE cycle after DONE. Minimum spacing is WAIT_CYCLES+2 cycles between DONE cycles.
- Reset mid-ACCESS:
  - Next edge: IDLE, strobes drop, `mem_data` is cleared.
  - No partial write is acknowledged.
- `req` deasserting during ACCESS is illegal, since EX/MEM is frozen. The FSM completes the access regardless.
- Address arithmetic is 32-bit modular. Addresses below BASE_ADDR wrap; the result is truncated to ADDR_W.

## Test plan
- Reset: assert `rst` 2 cycles with `req` low. Required: all outputs 0; state IDLE.
- Load, WAIT_CYCLES=5: `mem_read=1`, `alu_result=1032`, `dest=3`, `wb_en=1`; `sram_rdata=32'hDEADBEEF` on the final ACCESS cycle. Required:
  - `freeze` high for cycles 0–5.
  - `sram_addr=2` and `sram_re=1` for cycles 1–5.
  - `wb_en_out=0` while frozen.
  - Cycle 6: `freeze=0`, `mem_data=32'hDEADBEEF`, `wb_en_out=1`, `dest_out=3`.
- Store: `mem_write=1`, `alu_result=1024`, `st_val=32'h12345678`. Required:
  - `sram_addr=0`, `sram_wdata=32'h12345678`, and `sram_we=1` for exactly 5 cycles.
  - `mem_data` unchanged.
  - Cycle 6: `freeze=0`.
- Pass-through: `mem_read=mem_write=0`, `wb_en=1`, `alu_result=7`, `dest=9`. Required: `freeze=0`, same-cycle `alu_result_out=7`, `wb_en_out=1`, `dest_out=9`; strobes 0.
- Back-to-back: load then store on consecutive instructions. Required:
  - Exactly one IDLE cycle between the first DONE and the second ACCESS.
  - Two distinct strobe windows of 5 cycles each.
  - No double access.
- Reset during cycle 3 of a store. Required: next edge `sram_we=0` and state IDLE. With `req` still high, `freeze=1` and a fresh 6-cycle access begins.
